drink_display_scan: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver for the drink vending machine front panel. Successor to the single-digit combinational drink-code decoder: it latches NUM_DIGITS 5-bit display codes, decodes each to segments, and scans them onto a shared segment bus with a programmable refresh rate, inter-digit dead time, per-digit blinking and a global blank. Sits between the vending controller and the panel's common-cathode digit drivers.

---
 rtl/drink_disp_pkg.sv | 46 ++++
 rtl/drink_seg7_lut.sv | 43 ++++
 rtl/drink_display_scan.sv | 115 +++++++++++
 tb/tb_drink_display_scan.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/drink_disp_pkg.sv
// Shared constants for the drink display scanner.
// Holds the 5-bit display code values, the 7-bit glyph patterns in
// {a,b,c,d,e,f,g} order (bit 6 = segment a), and a one-hot helper.
package drink_disp_pkg;

    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;
    localparam logic [4:0] CODE_P     = 5'd18;
    localparam logic [4:0] CODE_L     = 5'd19;
    localparam logic [4:0] CODE_U     = 5'd20;
    localparam logic [4:0] CODE_N     = 5'd21;
    localparam logic [4:0] CODE_O     = 5'd22;
    localparam logic [4:0] CODE_R     = 5'd23;

    localparam logic [6:0] GLYPH_0     = 7'b1111110;
    localparam logic [6:0] GLYPH_1     = 7'b0110000;
    localparam logic [6:0] GLYPH_2     = 7'b1101101;
    localparam logic [6:0] GLYPH_3     = 7'b1111001;
    localparam logic [6:0] GLYPH_4     = 7'b0110011;
    localparam logic [6:0] GLYPH_5     = 7'b1011011;
    localparam logic [6:0] GLYPH_6     = 7'b1011111;
    localparam logic [6:0] GLYPH_7     = 7'b1110000;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1111011;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_B     = 7'b0011111;
    localparam logic [6:0] GLYPH_C     = 7'b1001110;
    localparam logic [6:0] GLYPH_D     = 7'b0111101;
    localparam logic [6:0] GLYPH_E     = 7'b1001111;
    localparam logic [6:0] GLYPH_F     = 7'b1000111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0000001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0] GLYPH_P     = 7'b1100111;
    localparam logic [6:0] GLYPH_L     = 7'b0001110;
    localparam logic [6:0] GLYPH_U     = 7'b0111110;
    localparam logic [6:0] GLYPH_N     = 7'b0010101;
    localparam logic [6:0] GLYPH_O     = 7'b0011101;
    localparam logic [6:0] GLYPH_R     = 7'b0000101;

    // One-hot of a digit index; callers size-cast to their digit count
    // (up to 32 digits).
    function automatic logic [31:0] onehot(input logic [4:0] i);
        return 32'd1 << i;
    endfunction

endpackage

// File: rtl/drink_seg7_lut.sv
// Combinational 5-bit display code to 7-segment glyph decoder.
// Ports:
//   code - 5-bit display code (0-15 hex, 16-23 symbols, 24-31 blank)
//   seg  - {a,b,c,d,e,f,g}, active-high
module drink_seg7_lut
    import drink_disp_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        case (code)
            5'd0:       seg = GLYPH_0;
            5'd1:       seg = GLYPH_1;
            5'd2:       seg = GLYPH_2;
            5'd3:       seg = GLYPH_3;
            5'd4:       seg = GLYPH_4;
            5'd5:       seg = GLYPH_5;
            5'd6:       seg = GLYPH_6;
            5'd7:       seg = GLYPH_7;
            5'd8:       seg = GLYPH_8;
            5'd9:       seg = GLYPH_9;
            5'd10:      seg = GLYPH_A;
            5'd11:      seg = GLYPH_B;
            5'd12:      seg = GLYPH_C;
            5'd13:      seg = GLYPH_D;
            5'd14:      seg = GLYPH_E;
            5'd15:      seg = GLYPH_F;
            CODE_DASH:  seg = GLYPH_DASH;
            CODE_BLANK: seg = GLYPH_BLANK;
            CODE_P:     seg = GLYPH_P;
            CODE_L:     seg = GLYPH_L;
            CODE_U:     seg = GLYPH_U;
            CODE_N:     seg = GLYPH_N;
            CODE_O:     seg = GLYPH_O;
            CODE_R:     seg = GLYPH_R;
            default:    seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/drink_display_scan.sv
// Time-multiplexed 7-segment display driver for the vending front panel.
// Latches NUM_DIGITS display codes, scans them onto a shared segment bus
// with one dead cycle between digit slots, per-digit blinking and a
// global blank.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   load        - single-cycle strobe capturing code_in and blink_en
//   code_in     - digit i code at bits [5i+4:5i], digit 0 rightmost
//   blink_en    - per-digit blink request
//   blank       - level, forces all digits off
//   seg         - {a,b,c,d,e,f,g}, active-high
//   digit_en    - one-hot digit select, active-high
//   frame_start - pulse in the dead cycle that precedes digit 0
module drink_display_scan
    import drink_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [5*NUM_DIGITS-1:0] code_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         bc;
    logic                  phase;
    logic [4:0]            shadow [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blink_sh;

    logic                  tick;
    logic                  last_digit;
    logic [6:0]            lut_seg;
    logic [6:0]            vis_seg;
    logic [NUM_DIGITS-1:0] sel;

    assign tick       = (pre == PW'(REFRESH_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));

    drink_seg7_lut u_lut (
        .code (shadow[idx]),
        .seg  (lut_seg)
    );

    // Blink-off phase suppresses segments but keeps the digit selected, so
    // the scan timing seen by the panel drivers never changes.
    assign vis_seg = (phase && blink_sh[idx]) ? GLYPH_BLANK : lut_seg;
    assign sel     = NUM_DIGITS'(onehot(5'(idx)));

    // Scan timing keeps running under blank so release resumes in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            idx   <= '0;
            bc    <= '0;
            phase <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                idx <= last_digit ? '0 : idx + 1'b1;
                if (bc == BW'(BLINK_TICKS - 1)) begin
                    bc    <= '0;
                    phase <= ~phase;
                end else begin
                    bc <= bc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= CODE_BLANK;
            end
            blink_sh <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= code_in[5*i +: 5];
            end
            blink_sh <= blink_en;
        end
    end

    // The tick cycle is a dead cycle: nothing driven while digit_en moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= '0;
            digit_en    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && last_digit;
            if (blank || tick) begin
                seg      <= '0;
                digit_en <= '0;
            end else begin
                seg      <= vis_seg;
                digit_en <= sel;
            end
        end
    end

endmodule

// File: tb/tb_drink_display_scan.sv
module tb_drink_display_scan;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           load;
    logic [5*N-1:0] code_in;
    logic [N-1:0]   blink_en;
    logic           blank;
    logic [6:0]     seg;
    logic [N-1:0]   digit_en;
    logic           frame_start;

    drink_display_scan #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLINK_TICKS (B)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .code_in     (code_in),
        .blink_en    (blink_en),
        .blank       (blank),
        .seg         (seg),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: t = clock edges seen since reset release; scan
    // position and blink phase follow from t arithmetically.
    int         t;
    logic [4:0] m_code  [N];
    logic       m_blink [N];
    logic [6:0] glyph   [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) begin
            m_code[i]  = 5'd17;
            m_blink[i] = 1'b0;
        end
    endtask

    task automatic step();
        int         pre, idx, ph;
        logic [6:0] es;
        logic [N-1:0] ed;
        logic       ef;
        pre = t % R;
        idx = (t / R) % N;
        ph  = ((t / R) / B) % 2;
        if (blank || pre == R - 1) begin
            es = 7'd0;
            ed = '0;
        end else begin
            ed = N'(1) << idx;
            es = (ph == 1 && m_blink[idx]) ? 7'd0 : glyph[m_code[idx]];
        end
        ef = (pre == R - 1) && (idx == N - 1);
        @(posedge clk);
        t++;
        if (load) begin
            for (int i = 0; i < N; i++) begin
                m_code[i]  = code_in[5*i +: 5];
                m_blink[i] = blink_en[i];
            end
        end
        #1;
        chk("seg", 32'(seg), 32'(es));
        chk("digit_en", 32'(digit_en), 32'(ed));
        chk("frame_start", 32'(frame_start), 32'(ef));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [5*N-1:0] c, input logic [N-1:0] b);
        code_in  = c;
        blink_en = b;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    initial begin
        glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000;
        glyph[2]  = 7'b1101101; glyph[3]  = 7'b1111001;
        glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
        glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000;
        glyph[8]  = 7'b1111111; glyph[9]  = 7'b1111011;
        glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
        glyph[12] = 7'b1001110; glyph[13] = 7'b0111101;
        glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;
        glyph[16] = 7'b0000001; glyph[17] = 7'b0000000;
        glyph[18] = 7'b1100111; glyph[19] = 7'b0001110;
        glyph[20] = 7'b0111110; glyph[21] = 7'b0010101;
        glyph[22] = 7'b0011101; glyph[23] = 7'b0000101;
        for (int i = 24; i < 32; i++) glyph[i] = 7'b0000000;

        rst      = 1'b1;
        load     = 1'b0;
        blank    = 1'b0;
        code_in  = '0;
        blink_en = '0;
        model_reset();

        #12;
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_digit_en", 32'(digit_en), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        run(20);

        do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000);
        run(20);

        do_load({5'd18, 5'd23, 5'd16, 5'd22}, 4'b0010);
        run(48);

        do_load({5'd27, 5'd26, 5'd25, 5'd24}, 4'b0000);
        run(16);
        do_load({5'd31, 5'd30, 5'd29, 5'd28}, 4'b1111);
        run(16);

        do_load({5'd8, 5'd10, 5'd15, 5'd19}, 4'b0100);
        run(5);
        blank = 1'b1;
        run(10);
        blank = 1'b0;
        run(20);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                code_in  = (5*N)'($urandom);
                blink_en = N'($urandom);
                load     = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) blank = ~blank;
            step();
            load = 1'b0;
        end
        blank = 1'b0;

        do_load({5'd1, 5'd2, 5'd3, 5'd4}, 4'b0000);
        run(5);
        #2;
        code_in = {5'd9, 5'd9, 5'd9, 5'd9};
        load    = 1'b1;
        rst     = 1'b1;
        #1;
        chk("async_rst_seg", 32'(seg), 32'd0);
        chk("async_rst_digit_en", 32'(digit_en), 32'd0);
        chk("async_rst_frame_start", 32'(frame_start), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("held_rst_seg", 32'(seg), 32'd0);
        chk("held_rst_digit_en", 32'(digit_en), 32'd0);
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b0;
        run(24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
